// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - character-RAM write controller for the text console
// Turns a byte stream into cursor-addressed RAM writes, with line and full-screen clearing.
module text_console_writer #(
   parameter int COLS   = 20,
   parameter int ROWS   = 15,
   parameter int ADDR_W = 9
) (
   input  logic              px_clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              clear,
   output logic              busy,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [4:0]        cursor_col,
   output logic [3:0]        cursor_row
);

   // One spare bit so the counter can reach ROWS*COLS even when it equals 2**ADDR_W.
   localparam int               CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(ROWS * COLS);
   localparam logic [CNT_W-1:0] LINE     = CNT_W'(COLS);
   localparam logic [4:0]       LAST_COL = 5'(COLS - 1);
   localparam logic [3:0]       LAST_ROW = 4'(ROWS - 1);
   localparam logic [7:0]       SPACE    = 8'h20;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_CLRLINE,
      ST_IDLE
   } state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               wr_en_n;
   logic [ADDR_W-1:0]  wr_addr_n;
   logic [7:0]         wr_data_n;
   logic [4:0]         col_n;
   logic [3:0]         row_n;
   logic [3:0]         next_row;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] row, input int col);
      return ADDR_W'(int'(row) * COLS + col);
   endfunction

   assign in_ready = (state == ST_IDLE) && !clear;
   assign busy     = (state == ST_CLEAR) || (state == ST_CLRLINE);
   // The screen wraps to the top row instead of scrolling.
   assign next_row = (cursor_row == LAST_ROW) ? 4'd0 : cursor_row + 4'd1;

   always_ff @(posedge px_clk or posedge rst) begin
      if (rst) begin
         state      <= ST_CLEAR;
         cnt        <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= SPACE;
         cursor_col <= 5'd0;
         cursor_row <= 4'd0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         wr_en      <= wr_en_n;
         wr_addr    <= wr_addr_n;
         wr_data    <= wr_data_n;
         cursor_col <= col_n;
         cursor_row <= row_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      wr_en_n   = 1'b0;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;
      col_n     = cursor_col;
      row_n     = cursor_row;

      if (clear) begin
         state_n = ST_CLEAR;
         cnt_n   = '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (cnt == TOTAL) begin
                  state_n = ST_IDLE;
                  col_n   = 5'd0;
                  row_n   = 4'd0;
               end else begin
                  wr_en_n   = 1'b1;
                  wr_addr_n = cnt[ADDR_W-1:0];
                  wr_data_n = SPACE;
                  cnt_n     = cnt + 1'b1;
               end
            end

            ST_CLRLINE: begin
               if (cnt == LINE) begin
                  state_n = ST_IDLE;
               end else begin
                  wr_en_n   = 1'b1;
                  wr_addr_n = addr_of(cursor_row, int'(cnt));
                  wr_data_n = SPACE;
                  cnt_n     = cnt + 1'b1;
               end
            end

            default: begin
               if (in_valid) begin
                  if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                     wr_en_n   = 1'b1;
                     wr_addr_n = addr_of(cursor_row, int'(cursor_col));
                     wr_data_n = in_data;
                     if (cursor_col == LAST_COL) begin
                        // Character write goes out first; the line clear follows it.
                        col_n   = 5'd0;
                        row_n   = next_row;
                        state_n = ST_CLRLINE;
                        cnt_n   = '0;
                     end else begin
                        col_n = cursor_col + 5'd1;
                     end
                  end else if (in_data == 8'h0A) begin
                     // LF issues column 0 of the new row itself, so the clear starts next cycle.
                     wr_en_n   = 1'b1;
                     wr_addr_n = addr_of(next_row, 0);
                     wr_data_n = SPACE;
                     col_n     = 5'd0;
                     row_n     = next_row;
                     state_n   = ST_CLRLINE;
                     cnt_n     = CNT_W'(1);
                  end else if (in_data == 8'h0D) begin
                     col_n = 5'd0;
                  end else if (in_data == 8'h08) begin
                     if (cursor_col != 5'd0) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = addr_of(cursor_row, int'(cursor_col) - 1);
                        wr_data_n = SPACE;
                        col_n     = cursor_col - 5'd1;
                     end
                  end else if (in_data == 8'h0C) begin
                     state_n = ST_CLEAR;
                     cnt_n   = '0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Write-side controller for the character RAM of the VGA text display. It turns a byte stream into character-RAM writes at a text cursor and interprets a small set of control codes. It also handles row wrap-around with line clearing and full-screen clear sequencing. It drives the RAM write port (`wclk` = `px_clk`) in the pixel clock domain; the display read path is untouched.

## Interface
- `COLS`, 20, characters per row; this is also the row stride of the RAM address.
- `ROWS`, 15, text rows.
- `ADDR_W`, 9, RAM address width; `ROWS*COLS <= 2**ADDR_W` is required.
- `px_clk`  in  1  pixel clock; the single clock of the block.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  8  character or control code.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a byte; a byte is accepted when `in_valid && in_ready`.
- `clear`  in  1  one-cycle request to clear the screen and home the cursor.
- `busy`  out  1  a clear sequence (full or line) is in progress.
- `wr_en`  out  1  RAM write enable.
- `wr_addr`  out  `ADDR_W`  RAM write address.
- `wr_data`  out  8  RAM write data.
- `cursor_col`  out  5  current column, range 0..COLS-1.
- `cursor_row`  out  4  current row, range 0..ROWS-1.

## Operation
- Address rule: address = `row*COLS + col`, truncated to `ADDR_W` bits. An incremental linear counter is acceptable if it gives identical addresses.
- FSM states:
  - CLEAR: writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle, then homes the cursor to (0,0) and goes to IDLE.
  - CLRLINE: writes 0x20 to all COLS addresses of `cursor_row`, columns 0..COLS-1, then goes to IDLE with the cursor at (row,0).
  - IDLE: `in_ready`=1, `busy`=0.
- `in_ready` = (state==IDLE) && !`clear`. `busy` = (state==CLEAR || state==CLRLINE).
- Byte handling on accept in IDLE:
  - 0x20..0x7E (printable): write the byte at the cursor, then col+1. If col was COLS-1, the cursor moves to col 0 of the next row (see row advance).
  - 0x0A (LF): col=0, then row advance. No write for the LF itself.
  - 0x0D (CR): col=0, no write.
  - 0x08 (BS): if col>0, col-1 and write 0x20 at the new position. If col==0, no write and no cursor change.
  - 0x0C (FF): enter CLEAR, with the same effect as `clear`.
  - All other codes are consumed and ignored: no write, no cursor change.
- Row advance:
  - If row < ROWS-1: row+1 and enter CLRLINE for the new row.
  - If row == ROWS-1: row=0 and enter CLRLINE for row 0. The screen wraps; it does not scroll.
- `clear` is honoured in any state. It restarts CLEAR from address 0, even mid-CLEAR or mid-CLRLINE.
- If `clear` and `in_valid` are high in the same cycle, `clear` wins and the byte is not accepted (`in_ready` is low).
- When `wr_en`=0, `wr_addr` and `wr_data` hold their last values.

## Timing
- All outputs are registered except `in_ready` and `busy`, which decode the registered state (plus `clear` for `in_ready`).
- Write latency: an accept in cycle N produces `wr_en`=1 with the matching address and data in cycle N+1. Cursor outputs update in cycle N+1.
- CLEAR takes exactly ROWS*COLS consecutive write cycles (300 at defaults). `busy` falls and `in_ready` rises in the cycle after the last write.
- CLRLINE takes exactly COLS consecutive write cycles (20 at defaults), starting in the cycle after the triggering accept.
  - When a printable character at col COLS-1 triggers it, the character write occupies cycle N+1 and the line clear starts at N+2.
- Throughput in IDLE is one byte per cycle for printable characters, CR, BS and ignored codes.
- Reset values: state=CLEAR with counter 0, `wr_en`=0, `wr_addr`=0, `wr_data`=0x20, cursor (0,0), `busy`=1, `in_ready`=0.
  - After `rst` falls, the first clear write (addr 0) appears on the first `px_clk` edge.
- Reset asserted mid-sequence: all outputs return immediately (asynchronously) to their reset values, and the full CLEAR reruns after release.

## Test plan
- Reset release: 300 writes of 0x20 at addrs 0..299, one per cycle, in order. Then `busy`=0, `in_ready`=1, cursor (0,0).
- Send "AB" back to back: writes (0,0x41) then (1,0x42) in consecutive cycles; cursor ends at (0,2).
- Cursor at (14,19), send 0x5A: write (299,0x5A), then 20 writes of 0x20 at addrs 0..19 with `busy`=1; cursor ends at (0,0).
- Cursor at (2,3), send 0x08: write (42,0x20), cursor (2,2). Send CR then 0x08: no writes, cursor (2,0).
- `clear` and `in_valid`(0x41) high in the same cycle in IDLE: no 0x41 write; a 300-write clear follows. A `clear` pulse at clear step 100 restarts the clear from addr 0.
- Assert `rst` mid-CLRLINE: `wr_en` drops to 0 without waiting for a clock edge. After release, a full 300-write clear occurs and the cursor is (0,0).
